pic_ctrl_gen: RTL
=================

Name: pic_ctrl_gen

Overview:
- Clocked, parametrised successor of the 8259A-style PIC; fully synchronous single-clock design.
- Holds request (IRR), mask (IMR) and in-service (ISR) state for NUM_IR interrupt lines.
- Resolves priority in fully nested or auto-rotating mode and drives INT to the CPU.
- On an INTA handshake, returns a vector equal to the programmed base plus the winning line index.

Parameters:
NUM_IR, 8, number of interrupt request lines (2..DATA_W)
DATA_W, 8, CPU data bus width; also vector width
IDX_W, $clog2(NUM_IR), width of the line index and rotation pointer

Ports:
CLK  input  1  system clock; all state changes on the rising edge
RST  input  1  synchronous, active-high reset
IR  input  NUM_IR  request lines, synchronous to CLK
WR  input  1  register write strobe, one cycle per write
RD  input  1  register read strobe
ADDR  input  2  register select
WDATA  input  DATA_W  write data
RDATA  output  DATA_W  read data, registered
INT  output  1  interrupt request to the CPU, registered
INTA  input  1  acknowledge; a rising edge (sampled 0 then 1) is one acknowledge
VECTOR  output  DATA_W  vector of the last acknowledge, registered
VEC_VALID  output  1  one-cycle pulse when VECTOR is updated

Behaviour:
- Reset (synchronous, RST=1 at a CLK edge): IRR=0, ISR=0, IMR=all ones, LOW=NUM_IR-1 (IR0 highest), BASE=0, LTIM=AEOI=ROTATE=0. Outputs INT=0, VECTOR=0, VEC_VALID=0, RDATA=0. RST overrides every other input in that cycle.
- Writes:
  - ADDR0 (mode): bit0 LTIM, bit1 AEOI, bit2 ROTATE. A mode write also clears IRR and ISR, sets IMR to all ones, and sets LOW=NUM_IR-1.
  - ADDR1: IMR = WDATA[NUM_IR-1:0].
  - ADDR2 (command): WDATA[7:5]=001 non-specific EOI; 011 specific EOI of line WDATA[IDX_W-1:0]; 101 non-specific EOI plus rotate; 110 set LOW=WDATA[IDX_W-1:0]. Other codes are ignored.
  - ADDR3: BASE = WDATA.
- Reads: on RD, RDATA is valid the next cycle and is held until the next RD. ADDR0 returns IRR, 1 returns IMR, 2 returns ISR, 3 returns BASE. Unused upper bits read 0.
- Request capture:
  - Edge mode (LTIM=0): an IR bit sampled 1 after 0 sets the IRR bit the next cycle. The bit holds until acknowledged.
  - Level mode (LTIM=1): IRR = IR registered each cycle.
- Priority:
  - Highest priority is (LOW+1) mod NUM_IR, descending cyclically.
  - Eligible = IRR & ~IMR, restricted to lines strictly higher in priority than the highest-priority ISR bit (fully nested).
  - INT(next) = any eligible AND not in an acknowledge cycle.
  - Latency: edge sampled at edge k -> IRR at k+1 -> INT at k+2.
- Acknowledge (INTA rising edge detected at edge k):
  - The winner W is the highest eligible line, evaluated on pre-edge state.
  - ISR[W] is set unless AEOI=1. In edge mode IRR[W] is cleared.
  - VECTOR = BASE + W; VEC_VALID=1 for exactly one cycle after edge k; INT=0 after edge k.
  - If ROTATE=1 and AEOI=1, LOW=W.
  - No eligible line gives a spurious acknowledge: VECTOR = BASE + NUM_IR-1, ISR and IRR unchanged.
  - A held INTA is not re-acknowledged; INT re-evaluates normally while INTA stays high.
- EOI:
  - Non-specific EOI clears the highest-priority ISR bit; no effect if ISR=0.
  - Rotate-EOI additionally sets LOW to the cleared line.
- Simultaneous events:
  - ISR_next = (ISR & ~eoi_clear) | ack_set.
  - An IR edge on the same line in an acknowledge cycle re-sets IRR (the set wins).
  - A mode write in an acknowledge cycle wins: no ISR set and no VEC_VALID.
  - An IMR write takes effect for eligibility from the next cycle.
  - An RST asserted mid-handshake aborts it; the following INTA edge counts only after a 0 has been sampled.
- Arithmetic: BASE + W uses DATA_W-bit wrap-around addition. Pointer math is mod NUM_IR; non-power-of-2 NUM_IR is supported.

Test Plan:
- Reset -> INT=0, VEC_VALID=0; read ADDR1 -> RDATA=0xFF; read ADDR2 -> 0x00.
- IMR=0x00, BASE=0x20, pulse IR3 at edge k -> INT=1 at k+2; INTA edge -> VECTOR=0x23, VEC_VALID one cycle, ISR=0x08, IRR=0x00.
- Fully nested: ISR=0x20 (IR5 in service). IR6 pulse -> INT stays 0. IR2 pulse -> INT=1, ack vector BASE+2, ISR=0x24. Non-specific EOI -> ISR=0x20, and a pending IR6 stays blocked until a second EOI.
- ROTATE=1, AEOI=1, IR1 and IR4 pending -> acks give BASE+1 then BASE+4, ISR=0. Then IR0 and IR5 pending -> BASE+5 wins.
- Spurious: INTA edge with no eligible line -> VECTOR=BASE+NUM_IR-1, ISR unchanged. Level mode: IR2 dropped before INTA -> spurious.
- NUM_IR=5 instance: LOW=4 -> IR0 highest; command 110 with LOW=2 -> IR3 beats IR0 and IR4; mode write during INTA -> no VEC_VALID.

Source files
------------

// File: rtl/pic_ctrl_gen.sv
// Parametrised 8259A-style interrupt controller: IRR/IMR/ISR state, nested or rotating
// priority, INT generation and an INTA handshake that returns BASE + winning line.
module pic_ctrl_gen #(
    parameter int NUM_IR = 8,
    parameter int DATA_W = 8,
    parameter int IDX_W  = $clog2(NUM_IR)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NUM_IR-1:0] IR,
    input  logic              WR,
    input  logic              RD,
    input  logic [1:0]        ADDR,
    input  logic [DATA_W-1:0] WDATA,
    output logic [DATA_W-1:0] RDATA,
    output logic              INT,
    input  logic              INTA,
    output logic [DATA_W-1:0] VECTOR,
    output logic              VEC_VALID
);

    logic [NUM_IR-1:0] irr_q, irr_d, imr_q, imr_d, isr_q, isr_d;
    logic [NUM_IR-1:0] ir_q, ir_prev_q, req, eoi_clr, ack_set, irr_clr;
    logic [IDX_W-1:0]  low_q, low_d, isr_top, win_idx, cmd_idx;
    logic [DATA_W-1:0] base_q, rdata_q, vector_q, vector_d;
    logic              ltim_q, aeoi_q, rotate_q, int_q, vec_valid_q, inta_prev_q;
    logic              isr_hit, win_hit, ack, mode_wr, cmd_wr, idx_ok;
    logic [2:0]        cmd;
    int                isr_rank;

    // Line that sits k steps below the highest-priority position (LOW+1).
    function automatic logic [IDX_W-1:0] line_at(input logic [IDX_W-1:0] low, input int k);
        int l;
        l = int'(low) + 1 + k;
        if (l >= NUM_IR) l = l - NUM_IR;
        return IDX_W'(l);
    endfunction

    function automatic logic [NUM_IR-1:0] onehot(input logic [IDX_W-1:0] i);
        return NUM_IR'(1) << i;
    endfunction

    assign req     = irr_q & ~imr_q;
    assign ack     = INTA & ~inta_prev_q;
    assign mode_wr = WR && (ADDR == 2'd0);
    assign cmd_wr  = WR && (ADDR == 2'd2);
    assign cmd     = WDATA[7:5];
    assign cmd_idx = WDATA[IDX_W-1:0];
    assign idx_ok  = int'(cmd_idx) < NUM_IR;

    // Scan in priority order: first the top in-service line, then the best request above it.
    always_comb begin
        isr_hit  = 1'b0;
        isr_top  = '0;
        isr_rank = NUM_IR;
        for (int k = 0; k < NUM_IR; k++) begin
            if (!isr_hit && isr_q[line_at(low_q, k)]) begin
                isr_hit  = 1'b1;
                isr_top  = line_at(low_q, k);
                isr_rank = k;
            end
        end
        win_hit = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NUM_IR; k++) begin
            if (!win_hit && (k < isr_rank) && req[line_at(low_q, k)]) begin
                win_hit = 1'b1;
                win_idx = line_at(low_q, k);
            end
        end
    end

    always_comb begin
        eoi_clr  = '0;
        ack_set  = '0;
        irr_clr  = '0;
        low_d    = low_q;
        imr_d    = imr_q;
        vector_d = vector_q;
        if (ack && win_hit) begin
            if (!aeoi_q) ack_set = onehot(win_idx);
            if (!ltim_q) irr_clr = onehot(win_idx);
            if (rotate_q && aeoi_q) low_d = win_idx;
        end
        if (ack) begin
            vector_d = base_q + (win_hit ? DATA_W'(win_idx) : DATA_W'(NUM_IR - 1));
        end
        if (cmd_wr) begin
            case (cmd)
                3'b001: if (isr_hit) eoi_clr = onehot(isr_top);
                3'b011: if (idx_ok) eoi_clr = onehot(cmd_idx);
                3'b101: if (isr_hit) begin
                    eoi_clr = onehot(isr_top);
                    low_d   = isr_top;
                end
                3'b110: if (idx_ok) low_d = cmd_idx;
                default: ;
            endcase
        end
        if (WR && (ADDR == 2'd1)) imr_d = WDATA[NUM_IR-1:0];
        isr_d = (isr_q & ~eoi_clr) | ack_set;
        // A fresh edge in the acknowledge cycle re-sets the bit the ack just cleared.
        irr_d = ltim_q ? IR : ((irr_q & ~irr_clr) | (ir_q & ~ir_prev_q));
        if (mode_wr) begin
            irr_d    = '0;
            isr_d    = '0;
            imr_d    = '1;
            low_d    = IDX_W'(NUM_IR - 1);
            vector_d = vector_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            irr_q       <= '0;
            isr_q       <= '0;
            imr_q       <= '1;
            low_q       <= IDX_W'(NUM_IR - 1);
            base_q      <= '0;
            ltim_q      <= 1'b0;
            aeoi_q      <= 1'b0;
            rotate_q    <= 1'b0;
            int_q       <= 1'b0;
            vector_q    <= '0;
            vec_valid_q <= 1'b0;
            rdata_q     <= '0;
            ir_q        <= '1;
            ir_prev_q   <= '1;
            // Held high so an INTA still asserted across reset is not taken as an edge.
            inta_prev_q <= 1'b1;
        end else begin
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            imr_q       <= imr_d;
            low_q       <= low_d;
            ir_q        <= IR;
            ir_prev_q   <= ir_q;
            inta_prev_q <= INTA;
            int_q       <= win_hit && !ack;
            vector_q    <= vector_d;
            vec_valid_q <= ack && !mode_wr;
            if (mode_wr) begin
                ltim_q   <= WDATA[0];
                aeoi_q   <= WDATA[1];
                rotate_q <= WDATA[2];
            end
            if (WR && (ADDR == 2'd3)) base_q <= WDATA;
            if (RD) begin
                case (ADDR)
                    2'd0:    rdata_q <= DATA_W'(irr_q);
                    2'd1:    rdata_q <= DATA_W'(imr_q);
                    2'd2:    rdata_q <= DATA_W'(isr_q);
                    default: rdata_q <= base_q;
                endcase
            end
        end
    end

    assign RDATA     = rdata_q;
    assign INT       = int_q;
    assign VECTOR    = vector_q;
    assign VEC_VALID = vec_valid_q;

endmodule
